ddr4_ca_lane_ctrl: RTL and testbench

- Fabric-side controller for a parametrised group of DDR4 address/command IOD lanes.
- Per lane, it packs serialized TX and OE slot data, and generates idle and output-enable hold-off behaviour.
- It also runs a per-lane output delay-line training FSM that drives the IOD MOVE/DIRECTION/LOAD pins and tracks tap position.
- Sits between the DDR4 sequencer/training logic and the per-pin PF_IOD wrappers in the DDRPHY block, replacing hand-wired single-lane tie-offs.

---
 rtl/ddr4_ca_pkg.sv | 23 ++
 rtl/ddr4_ca_dl_fsm.sv | 138 +++++++++++++
 rtl/ddr4_ca_lane_ctrl.sv | 81 ++++++++
 tb/tb_ddr4_ca_lane_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_ca_pkg.sv
// Shared types and sizing helpers for the DDR4 CA lane controller.
package ddr4_ca_pkg;

    typedef enum logic [2:0] {
        DL_IDLE,
        DL_LOAD,
        DL_SETTLE,
        DL_STEP,
        DL_GAP,
        DL_DONE
    } dl_state_t;

    // Lane-index width; a single-lane build still gets a 1-bit index.
    function automatic int lane_w(input int num_lanes);
        return (num_lanes <= 1) ? 1 : $clog2(num_lanes);
    endfunction

    // Width of a down-counter that must hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ddr4_ca_dl_fsm.sv
// Per-lane output delay-line training FSM: drives IOD MOVE/DIRECTION/LOAD for one
// latched lane at a time and tracks the absolute tap position of every lane.
module ddr4_ca_dl_fsm import ddr4_ca_pkg::*; #(
    parameter int NUM_LANES  = 14,
    parameter int TAP_W      = 8,
    parameter int SETTLE_CYC = 4,
    parameter int MOVE_GAP   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dl_req,
    input  logic [lane_w(NUM_LANES)-1:0] dl_lane,
    input  logic [TAP_W-1:0]             dl_target,
    input  logic                         dl_reload,
    output logic                         dl_busy,
    output logic                         dl_ack,
    output logic                         dl_err,
    output logic [NUM_LANES*TAP_W-1:0]   tap_pos,
    output logic [NUM_LANES-1:0]         dl_move,
    output logic [NUM_LANES-1:0]         dl_dir,
    output logic [NUM_LANES-1:0]         dl_load,
    input  logic [NUM_LANES-1:0]         dl_oor
);

    localparam int LW       = lane_w(NUM_LANES);
    localparam int WAIT_MAX = (SETTLE_CYC > MOVE_GAP) ? SETTLE_CYC : MOVE_GAP;
    localparam int WW       = cnt_w(WAIT_MAX);

    dl_state_t            state;
    logic [LW-1:0]        lane_q;
    logic [TAP_W-1:0]     target_q;
    logic [WW-1:0]        wait_cnt;
    logic [TAP_W-1:0]     tap_q [NUM_LANES];

    logic                 lane_ok;
    logic [NUM_LANES-1:0] req_oh;
    logic [NUM_LANES-1:0] lane_oh;
    logic [TAP_W-1:0]     req_pos;
    logic [TAP_W-1:0]     cur_pos;

    assign lane_ok = 32'(dl_lane) < 32'(NUM_LANES);
    assign req_oh  = NUM_LANES'(1) << dl_lane;
    assign lane_oh = NUM_LANES'(1) << lane_q;
    assign req_pos = tap_q[dl_lane];
    assign cur_pos = tap_q[lane_q];
    assign dl_busy = (state != DL_IDLE);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_tap_out
        assign tap_pos[i*TAP_W +: TAP_W] = tap_q[i];
    end

    // Outputs are registered on the transition into the state that owns them, so
    // each pulse lines up exactly with its state and clears when the state exits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DL_IDLE;
            lane_q   <= '0;
            target_q <= '0;
            wait_cnt <= '0;
            dl_ack   <= 1'b0;
            dl_err   <= 1'b0;
            dl_move  <= '0;
            dl_dir   <= '0;
            dl_load  <= '0;
            // NOTE: the tap array is reset on purpose: after reset the IOD tap is
            // unknown, and a cleared tracker forces software to reload.
            for (int i = 0; i < NUM_LANES; i++) tap_q[i] <= '0;
        end else begin
            dl_ack  <= 1'b0;
            dl_err  <= 1'b0;
            dl_move <= '0;
            dl_load <= '0;
            case (state)
                DL_IDLE: begin
                    if (dl_req) begin
                        lane_q   <= dl_lane;
                        target_q <= dl_target;
                        if (!lane_ok) begin
                            state  <= DL_DONE;
                            dl_ack <= 1'b1;
                            dl_err <= 1'b1;
                        end else if (dl_reload) begin
                            state   <= DL_LOAD;
                            dl_load <= req_oh;
                        end else if (dl_target == req_pos) begin
                            state  <= DL_DONE;
                            dl_ack <= 1'b1;
                        end else begin
                            state   <= DL_STEP;
                            dl_move <= req_oh;
                            dl_dir  <= (dl_target > req_pos) ? req_oh : '0;
                        end
                    end
                end
                DL_LOAD: begin
                    tap_q[lane_q] <= '0;
                    wait_cnt      <= WW'(SETTLE_CYC - 1);
                    state         <= DL_SETTLE;
                end
                DL_SETTLE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end else if (target_q == '0) begin
                        state  <= DL_DONE;
                        dl_ack <= 1'b1;
                    end else begin
                        state   <= DL_STEP;
                        dl_move <= lane_oh;
                        dl_dir  <= (target_q > cur_pos) ? lane_oh : '0;
                    end
                end
                DL_STEP: begin
                    tap_q[lane_q] <= dl_dir[lane_q] ? cur_pos + TAP_W'(1)
                                                    : cur_pos - TAP_W'(1);
                    wait_cnt      <= WW'(MOVE_GAP - 1);
                    state         <= DL_GAP;
                end
                DL_GAP: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end else if (dl_oor[lane_q] || cur_pos == target_q) begin
                        state  <= DL_DONE;
                        dl_ack <= 1'b1;
                        dl_err <= dl_oor[lane_q];
                        dl_dir <= '0;
                    end else begin
                        state   <= DL_STEP;
                        dl_move <= lane_oh;
                        dl_dir  <= (target_q > cur_pos) ? lane_oh : '0;
                    end
                end
                DL_DONE: state <= DL_IDLE;
                default: state <= DL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ddr4_ca_lane_ctrl.sv
// Fabric-side controller for a group of DDR4 CA IOD lanes: registered TX/OE slot
// packing with idle fill and OE hold-off, ODT pass-through, and delay-line training.
module ddr4_ca_lane_ctrl import ddr4_ca_pkg::*; #(
    parameter int   NUM_LANES  = 14,
    parameter int   RATIO      = 4,
    parameter int   TAP_W      = 8,
    parameter logic IDLE_VALUE = 1'b1,
    parameter int   OE_HOLD    = 3,
    parameter int   SETTLE_CYC = 4,
    parameter int   MOVE_GAP   = 2
) (
    input  logic                         FAB_CLK,
    input  logic                         ARST_N,
    input  logic                         CA_VALID,
    input  logic [NUM_LANES*RATIO-1:0]   CA_DATA,
    input  logic                         CA_OE_EN,
    input  logic                         ODT_REQ,
    output logic [NUM_LANES*RATIO-1:0]   TX_DATA_O,
    output logic [NUM_LANES*RATIO-1:0]   OE_DATA_O,
    output logic                         ODT_EN_O,
    input  logic                         DL_REQ,
    input  logic [lane_w(NUM_LANES)-1:0] DL_LANE,
    input  logic [TAP_W-1:0]             DL_TARGET,
    input  logic                         DL_RELOAD,
    output logic                         DL_BUSY,
    output logic                         DL_ACK,
    output logic                         DL_ERR,
    output logic [NUM_LANES*TAP_W-1:0]   TAP_POS,
    output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE
);

    localparam int SLOTS = NUM_LANES * RATIO;
    localparam int HW    = cnt_w(OE_HOLD);

    logic [HW-1:0] hold_cnt;

    // Hold counter keeps OE up for OE_HOLD cycles after the last command so the
    // pads do not float between back-to-back bursts; CA_OE_EN overrides it.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            TX_DATA_O <= {SLOTS{IDLE_VALUE}};
            OE_DATA_O <= '0;
            ODT_EN_O  <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            TX_DATA_O <= CA_VALID ? CA_DATA : {SLOTS{IDLE_VALUE}};
            OE_DATA_O <= (CA_OE_EN && (CA_VALID || hold_cnt != '0)) ? '1 : '0;
            ODT_EN_O  <= ODT_REQ;
            if (CA_VALID)
                hold_cnt <= HW'(OE_HOLD);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HW'(1);
        end
    end

    ddr4_ca_dl_fsm #(
        .NUM_LANES (NUM_LANES),
        .TAP_W     (TAP_W),
        .SETTLE_CYC(SETTLE_CYC),
        .MOVE_GAP  (MOVE_GAP)
    ) u_dl_fsm (
        .clk      (FAB_CLK),
        .rst_n    (ARST_N),
        .dl_req   (DL_REQ),
        .dl_lane  (DL_LANE),
        .dl_target(DL_TARGET),
        .dl_reload(DL_RELOAD),
        .dl_busy  (DL_BUSY),
        .dl_ack   (DL_ACK),
        .dl_err   (DL_ERR),
        .tap_pos  (TAP_POS),
        .dl_move  (DELAY_LINE_MOVE),
        .dl_dir   (DELAY_LINE_DIRECTION),
        .dl_load  (DELAY_LINE_LOAD),
        .dl_oor   (DELAY_LINE_OUT_OF_RANGE)
    );

endmodule

// File: tb/tb_ddr4_ca_lane_ctrl.sv
// Scoreboard bench for ddr4_ca_lane_ctrl: stimulus pushes expected responses, a
// monitor pops them on every TX cycle and on every DL_ACK.
module tb_ddr4_ca_lane_ctrl;

    localparam int NL      = 14;
    localparam int R       = 4;
    localparam int TW      = 8;
    localparam int LW      = 4;
    localparam int SL      = NL * R;
    localparam int OE_HOLD = 3;
    localparam int SETTLE  = 4;
    localparam int GAP     = 2;

    logic            FAB_CLK = 1'b0;
    logic            ARST_N  = 1'b0;
    logic            CA_VALID = 1'b0;
    logic [SL-1:0]   CA_DATA = '0;
    logic            CA_OE_EN = 1'b0;
    logic            ODT_REQ = 1'b0;
    logic [SL-1:0]   TX_DATA_O;
    logic [SL-1:0]   OE_DATA_O;
    logic            ODT_EN_O;
    logic            DL_REQ = 1'b0;
    logic [LW-1:0]   DL_LANE = '0;
    logic [TW-1:0]   DL_TARGET = '0;
    logic            DL_RELOAD = 1'b0;
    logic            DL_BUSY;
    logic            DL_ACK;
    logic            DL_ERR;
    logic [NL*TW-1:0] TAP_POS;
    logic [NL-1:0]   DELAY_LINE_MOVE;
    logic [NL-1:0]   DELAY_LINE_DIRECTION;
    logic [NL-1:0]   DELAY_LINE_LOAD;
    logic [NL-1:0]   DELAY_LINE_OUT_OF_RANGE = '0;

    ddr4_ca_lane_ctrl dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
        .CA_VALID(CA_VALID), .CA_DATA(CA_DATA), .CA_OE_EN(CA_OE_EN), .ODT_REQ(ODT_REQ),
        .TX_DATA_O(TX_DATA_O), .OE_DATA_O(OE_DATA_O), .ODT_EN_O(ODT_EN_O),
        .DL_REQ(DL_REQ), .DL_LANE(DL_LANE), .DL_TARGET(DL_TARGET), .DL_RELOAD(DL_RELOAD),
        .DL_BUSY(DL_BUSY), .DL_ACK(DL_ACK), .DL_ERR(DL_ERR), .TAP_POS(TAP_POS),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [SL-1:0] tx;
        logic [SL-1:0] oe;
        logic          odt;
    } tx_exp_t;

    typedef struct {
        logic            err;
        logic [NL*TW-1:0] taps;
        int              loads;
        int              moves;
        int              ups;
        int              busy_cyc;
    } dl_exp_t;

    tx_exp_t     tx_q[$];
    dl_exp_t     dl_q[$];
    logic [TW-1:0] model_tap [NL];
    int          since_valid = 1000;
    int          cur_lane = 0;
    bit          mon_en = 0;
    bit          dl_done = 0;

    function automatic logic [NL*TW-1:0] pack_taps();
        logic [NL*TW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*TW +: TW] = model_tap[i];
        return v;
    endfunction

    function automatic logic [NL-1:0] lane_mask(input int lane);
        return (lane < NL) ? (NL'(1) << lane) : '0;
    endfunction

    // Expected TX/OE/ODT for the cycle after these inputs; OE is high when enabled
    // and a command is present now or occurred within the last OE_HOLD cycles.
    task automatic drive_tx(input logic v, input logic [SL-1:0] d, input logic oe, input logic odt);
        tx_exp_t e;
        CA_VALID = v;
        CA_DATA  = d;
        CA_OE_EN = oe;
        ODT_REQ  = odt;
        e.tx  = v ? d : {SL{1'b1}};
        e.oe  = (oe && (v || since_valid <= OE_HOLD)) ? {SL{1'b1}} : '0;
        e.odt = odt;
        since_valid = v ? 1 : ((since_valid < 1000) ? since_valid + 1 : 1000);
        tx_q.push_back(e);
    endtask

    function automatic logic [SL-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[SL-1:0];
    endfunction

    // Issues one delay request, predicts its outcome from tap arithmetic, raises
    // OUT_OF_RANGE on the target lane after the oor_after-th move, and waits idle.
    task automatic issue_dl(input int lane, input int tgt, input logic reload, input int oor_after);
        dl_exp_t e;
        int start, n, moves, seen, cycles;
        bit up, inject;
        @(negedge FAB_CLK);
        DL_LANE   = LW'(lane);
        DL_TARGET = TW'(tgt);
        DL_RELOAD = reload;
        DL_REQ    = 1'b1;
        cur_lane  = lane;
        if (lane >= NL) begin
            e.err = 1'b1; e.loads = 0; moves = 0; up = 1'b0;
        end else begin
            start = reload ? 0 : int'(model_tap[lane]);
            n     = (tgt > start) ? tgt - start : start - tgt;
            up    = tgt > start;
            e.loads = reload ? 1 : 0;
            if (oor_after >= 1 && oor_after <= n) begin
                moves = oor_after; e.err = 1'b1;
            end else begin
                moves = n; e.err = 1'b0;
            end
            model_tap[lane] = TW'(up ? start + moves : start - moves);
        end
        e.moves    = moves;
        e.ups      = up ? moves : 0;
        e.busy_cyc = e.loads * (1 + SETTLE) + moves * (1 + GAP) + 1;
        e.taps     = pack_taps();
        dl_q.push_back(e);
        seen = 0; inject = 0; cycles = 0;
        forever begin
            @(negedge FAB_CLK);
            DL_REQ = 1'b0;
            if (lane < NL && DELAY_LINE_MOVE[lane]) begin
                seen++;
                if (seen == oor_after) inject = 1;
            end
            DELAY_LINE_OUT_OF_RANGE = (NL'($urandom()) & ~lane_mask(lane)) |
                                      (inject ? lane_mask(lane) : '0);
            if (!DL_BUSY) break;
            // A request while busy must be ignored.
            if ($urandom_range(0, 7) == 0) begin
                DL_REQ    = 1'b1;
                DL_LANE   = LW'($urandom_range(0, 15));
                DL_TARGET = TW'($urandom());
                DL_RELOAD = 1'($urandom());
            end
            cycles++;
            if (cycles > 1000) begin
                check("dl_timeout", 128'(1), 128'(0));
                break;
            end
        end
        DELAY_LINE_OUT_OF_RANGE = '0;
    endtask

    int busy_cnt = 0, load_cnt = 0, move_cnt = 0, up_cnt = 0;
    tx_exp_t tx_e;
    dl_exp_t dl_e;

    always @(posedge FAB_CLK) begin
        #1;
        if (!ARST_N) begin
            busy_cnt = 0; load_cnt = 0; move_cnt = 0; up_cnt = 0;
        end else if (mon_en) begin
            if (tx_q.size() > 0) begin
                tx_e = tx_q.pop_front();
                check("tx_data", 128'(TX_DATA_O), 128'(tx_e.tx));
                check("oe_data", 128'(OE_DATA_O), 128'(tx_e.oe));
                check("odt_en",  128'(ODT_EN_O),  128'(tx_e.odt));
            end
            check("dl_lane_isolation",
                  128'({(DELAY_LINE_LOAD | DELAY_LINE_MOVE | DELAY_LINE_DIRECTION) & ~lane_mask(cur_lane),
                        DELAY_LINE_LOAD & DELAY_LINE_MOVE}), 128'(0));
            check("dl_err_only_with_ack", 128'(DL_ERR & ~DL_ACK), 128'(0));
            if (DL_BUSY) busy_cnt++;
            if (|DELAY_LINE_LOAD) load_cnt++;
            if (|DELAY_LINE_MOVE) begin
                move_cnt++;
                if (|(DELAY_LINE_MOVE & DELAY_LINE_DIRECTION)) up_cnt++;
            end
            if (DL_ACK) begin
                if (dl_q.size() == 0) begin
                    check("dl_unexpected_ack", 128'(1), 128'(0));
                end else begin
                    dl_e = dl_q.pop_front();
                    check("dl_err",        128'(DL_ERR),   128'(dl_e.err));
                    check("dl_tap_pos",    128'(TAP_POS),  128'(dl_e.taps));
                    check("dl_load_count", 128'(load_cnt), 128'(dl_e.loads));
                    check("dl_move_count", 128'(move_cnt), 128'(dl_e.moves));
                    check("dl_up_moves",   128'(up_cnt),   128'(dl_e.ups));
                    check("dl_busy_cycles", 128'(busy_cnt), 128'(dl_e.busy_cyc));
                end
                busy_cnt = 0; load_cnt = 0; move_cnt = 0; up_cnt = 0;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_tx"},   128'(TX_DATA_O), 128'({SL{1'b1}}));
        check({tag, "_oe"},   128'(OE_DATA_O), 128'(0));
        check({tag, "_odt"},  128'(ODT_EN_O),  128'(0));
        check({tag, "_dl_flags"}, 128'({DL_BUSY, DL_ACK, DL_ERR}), 128'(0));
        check({tag, "_dl_pins"},
              128'({DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD}), 128'(0));
        check({tag, "_tap_pos"}, 128'(TAP_POS), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        logic [SL-1:0] d;
        int rl, rt, ro;
        for (int i = 0; i < NL; i++) model_tap[i] = '0;

        repeat (2) @(negedge FAB_CLK);
        check_reset_values("reset");
        ARST_N = 1'b1;
        mon_en = 1;

        // Idle with OE permitted, then a single command with lane 0 = 1010.
        repeat (3) begin @(negedge FAB_CLK); drive_tx(1'b0, rand_data(), 1'b1, 1'b0); end
        @(negedge FAB_CLK);
        d = rand_data();
        d[R-1:0] = 4'b1010;
        drive_tx(1'b1, d, 1'b1, 1'b1);
        repeat (6) begin @(negedge FAB_CLK); drive_tx(1'b0, rand_data(), 1'b1, 1'b0); end
        @(negedge FAB_CLK);
        drive_tx(1'b1, rand_data(), 1'b0, 1'b0);
        @(negedge FAB_CLK);
        drive_tx(1'b0, rand_data(), 1'b1, 1'b1);

        fork
            begin
                issue_dl(5, 3, 1'b1, 0);
                issue_dl(5, 1, 1'b0, 0);
                issue_dl(2, 10, 1'b0, 2);
                issue_dl(15, 7, 1'b0, 0);
                issue_dl(14, 0, 1'b1, 0);
                issue_dl(7, 0, 1'b1, 0);
                issue_dl(5, 1, 1'b0, 0);
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(negedge FAB_CLK);
                    rl = $urandom_range(0, 15);
                    rt = $urandom_range(0, 12);
                    ro = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                    issue_dl(rl, rt, 1'($urandom_range(0, 1)), ro);
                end
                dl_done = 1;
            end
            begin
                while (!dl_done) begin
                    @(negedge FAB_CLK);
                    if (!dl_done)
                        drive_tx($urandom_range(0, 2) == 0, rand_data(),
                                 $urandom_range(0, 5) != 0, 1'($urandom()));
                end
                CA_VALID = 1'b0;
            end
        join

        repeat (3) @(negedge FAB_CLK);
        check("tx_queue_drained", 128'(tx_q.size()), 128'(0));
        check("dl_queue_drained", 128'(dl_q.size()), 128'(0));

        // Reset in the middle of a stepping operation.
        DL_LANE   = LW'(3);
        DL_TARGET = (model_tap[3] > 5) ? TW'(0) : TW'(12);
        DL_RELOAD = 1'b0;
        DL_REQ    = 1'b1;
        cur_lane  = 3;
        @(negedge FAB_CLK);
        DL_REQ = 1'b0;
        for (int i = 0; i < 50 && !DELAY_LINE_MOVE[3]; i++) @(negedge FAB_CLK);
        check("mid_step_reached", 128'(DELAY_LINE_MOVE[3]), 128'(1));
        ARST_N = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge FAB_CLK);
        check_reset_values("held_reset");
        ARST_N = 1'b1;
        for (int i = 0; i < NL; i++) model_tap[i] = '0;
        @(negedge FAB_CLK);
        check("post_reset_idle", 128'({DL_BUSY, DL_ACK}), 128'(0));
        issue_dl(3, 2, 1'b0, 0);

        repeat (3) @(negedge FAB_CLK);
        check("final_dl_queue", 128'(dl_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
